// File: rtl/micro_io_hub.sv
// micro_io_hub: KCPSM6 port decode, read mux and edge-triggered IRQ hub; define MICRO_IRQ_SYNC_EN to synchronise irq_req
module micro_io_hub #(
    parameter int          N_CH      = 4,
    parameter logic [7:0]  CH_BASE   = 8'h00,
    parameter int          CH_SPAN   = 16,
    parameter logic [7:0]  CTRL_ADDR = 8'hF0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        port_id,
    input  logic [7:0]        out_port,
    input  logic              write_strobe,
    input  logic              read_strobe,
    output logic [7:0]        in_port,
    output logic              interrupt,
    input  logic              interrupt_ack,
    input  logic [N_CH*8-1:0] ch_rdata,
    output logic [N_CH-1:0]   ch_sel,
    output logic [N_CH-1:0]   ch_wr,
    output logic [N_CH-1:0]   ch_rd,
    output logic [7:0]        ch_addr,
    output logic [7:0]        ch_wdata,
    input  logic [N_CH-1:0]   irq_req
);
    localparam int         SW        = $clog2(CH_SPAN);
    localparam logic [7:0] PEND_ADDR = CTRL_ADDR + 8'd1;
    logic [8:0]      diff;
    logic [7:0]      off, win, rdata;
    logic            is_mask, is_pend, wr_mask, wr_pend;
    logic [N_CH-1:0] hit, mask, pending, irq_s, irq_prev;
    logic            in_service;
    assign diff    = {1'b0, port_id} - {1'b0, CH_BASE};
    assign off     = diff[7:0] & 8'(CH_SPAN - 1);
    assign win     = diff[7:0] >> SW;
    assign is_mask = port_id == CTRL_ADDR;
    assign is_pend = port_id == PEND_ADDR;
    assign wr_mask = write_strobe & is_mask;
    assign wr_pend = write_strobe & is_pend;
    always_comb begin
        hit   = '0;
        rdata = 8'h00;
        for (int i = 0; i < N_CH; i++)
            if (!diff[8] && !is_mask && !is_pend && win == 8'(i)) begin
                hit[i] = 1'b1;
                rdata  = ch_rdata[i*8 +: 8];
            end
    end
`ifdef MICRO_IRQ_SYNC_EN
    logic [N_CH-1:0] sync1, sync2;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq_req;
            sync2 <= sync1;
        end
    end
    assign irq_s = sync2;
`else
    assign irq_s = irq_req;
`endif
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ch_sel     <= '0;
            ch_wr      <= '0;
            ch_rd      <= '0;
            ch_addr    <= 8'h00;
            ch_wdata   <= 8'h00;
            in_port    <= 8'h00;
            mask       <= '0;
            pending    <= '0;
            irq_prev   <= '0;
            in_service <= 1'b0;
            interrupt  <= 1'b0;
        end else begin
            ch_sel     <= hit;
            ch_wr      <= write_strobe ? hit : '0;
            ch_rd      <= read_strobe ? hit : '0;
            ch_addr    <= |hit ? off : 8'h00;
            ch_wdata   <= (write_strobe && |hit) ? out_port : ch_wdata;
            in_port    <= is_mask ? 8'(mask) : is_pend ? 8'(pending) : rdata;
            mask       <= wr_mask ? out_port[N_CH-1:0] : mask;
            irq_prev   <= irq_s;
            // a fresh edge wins over a same-cycle W1C of that bit
            pending    <= (pending & ~(wr_pend ? out_port[N_CH-1:0] : '0)) | (irq_s & ~irq_prev);
            in_service <= wr_pend ? 1'b0 : (interrupt & interrupt_ack) ? 1'b1 : in_service;
            interrupt  <= (interrupt & interrupt_ack) ? 1'b0 : (|(pending & mask) & ~in_service);
        end
    end
endmodule

// File: tb/tb_micro_io_hub.sv
// tb_micro_io_hub: table-driven decode vectors plus directed IRQ and reset sequences
module tb_micro_io_hub;
`ifdef MICRO_IRQ_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    logic        clk = 1'b0, reset_n = 1'b0;
    logic [7:0]  port_id = 8'h00, out_port = 8'h00, in_port, ch_addr, ch_wdata;
    logic        write_strobe = 1'b0, read_strobe = 1'b0, interrupt, interrupt_ack = 1'b0;
    logic [31:0] ch_rdata = 32'hD4C35C1A;
    logic [3:0]  ch_sel, ch_wr, ch_rd, irq_req = 4'b0000;
    int          checks = 0, errors = 0;
    typedef struct {
        logic [7:0] pid, wd;
        logic       wr, rd;
        logic [3:0] sel, cwr, crd;
        logic [7:0] addr, inp;
    } vec_t;
    vec_t vt [9];
    micro_io_hub dut (
        .clk(clk), .reset_n(reset_n), .port_id(port_id), .out_port(out_port),
        .write_strobe(write_strobe), .read_strobe(read_strobe), .in_port(in_port),
        .interrupt(interrupt), .interrupt_ack(interrupt_ack), .ch_rdata(ch_rdata),
        .ch_sel(ch_sel), .ch_wr(ch_wr), .ch_rd(ch_rd), .ch_addr(ch_addr),
        .ch_wdata(ch_wdata), .irq_req(irq_req)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h exp %h", n, a, e);
        end
    endtask
    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        port_id = a;
        out_port = d;
        write_strobe = 1'b1;
        tick();
        write_strobe = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
    initial begin
        vt[0] = '{8'h33, 8'hA5, 1'b1, 1'b0, 4'b1000, 4'b1000, 4'b0000, 8'h03, 8'hD4};
        vt[1] = '{8'h12, 8'h00, 1'b0, 1'b1, 4'b0010, 4'b0000, 4'b0010, 8'h02, 8'h5C};
        vt[2] = '{8'h80, 8'h00, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 8'h00, 8'h00};
        vt[3] = '{8'h00, 8'h11, 1'b1, 1'b0, 4'b0001, 4'b0001, 4'b0000, 8'h00, 8'h1A};
        vt[4] = '{8'h2F, 8'h77, 1'b1, 1'b1, 4'b0100, 4'b0100, 4'b0100, 8'h0F, 8'hC3};
        vt[5] = '{8'h3F, 8'h00, 1'b0, 1'b0, 4'b1000, 4'b0000, 4'b0000, 8'h0F, 8'hD4};
        vt[6] = '{8'h40, 8'h55, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 8'h00, 8'h00};
        vt[7] = '{8'hF0, 8'h00, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 8'h00, 8'h00};
        vt[8] = '{8'hFF, 8'h66, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 8'h00, 8'h00};
        tick();
        chk("rst in_port", in_port, 8'h00);
        chk("rst ch_sel", ch_sel, 4'b0);
        chk("rst ch_wr", ch_wr, 4'b0);
        chk("rst interrupt", interrupt, 1'b0);
        chk("rst ch_wdata", ch_wdata, 8'h00);
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) begin
            port_id = vt[i].pid;
            out_port = vt[i].wd;
            write_strobe = vt[i].wr;
            read_strobe = vt[i].rd;
            tick();
            chk($sformatf("v%0d ch_sel", i), ch_sel, vt[i].sel);
            chk($sformatf("v%0d ch_wr", i), ch_wr, vt[i].cwr);
            chk($sformatf("v%0d ch_rd", i), ch_rd, vt[i].crd);
            chk($sformatf("v%0d ch_addr", i), ch_addr, vt[i].addr);
            chk($sformatf("v%0d in_port", i), in_port, vt[i].inp);
            if (vt[i].cwr != 4'b0) chk($sformatf("v%0d ch_wdata", i), ch_wdata, vt[i].wd);
            write_strobe = 1'b0;
            read_strobe = 1'b0;
            tick();
            chk($sformatf("v%0d wr pulse end", i), ch_wr, 4'b0);
            chk($sformatf("v%0d rd pulse end", i), ch_rd, 4'b0);
        end
        port_id = 8'h12;
        tick();
        chk("rd early in_port", in_port, 8'h5C);
        read_strobe = 1'b1;
        tick();
        chk("rd ch_rd", ch_rd, 4'b0010);
        chk("rd in_port", in_port, 8'h5C);
        read_strobe = 1'b0;
        tick();
        chk("rd ch_rd end", ch_rd, 4'b0);
        wr(8'hF0, 8'h05);
        irq_req = 4'b0100;
        repeat (LAT) tick();
        irq_req = 4'b0000;
        port_id = 8'hF1;
        tick();
        chk("irq2 interrupt", interrupt, 1'b1);
        chk("irq2 pending", in_port, 8'h04);
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        chk("ack drop", interrupt, 1'b0);
        tick();
        chk("in_service hold", interrupt, 1'b0);
        wr(8'hF1, 8'h04);
        tick();
        chk("w1c interrupt", interrupt, 1'b0);
        chk("w1c pending", in_port, 8'h00);
        irq_req = 4'b0010;
        repeat (LAT) tick();
        irq_req = 4'b0000;
        tick();
        chk("masked interrupt", interrupt, 1'b0);
        chk("masked pending", in_port, 8'h02);
        wr(8'hF0, 8'h07);
        chk("mask edge interrupt", interrupt, 1'b0);
        chk("mask old read", in_port, 8'h05);
        tick();
        chk("unmask interrupt", interrupt, 1'b1);
        chk("mask read", in_port, 8'h07);
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        wr(8'hF1, 8'h0F);
        tick();
        irq_req = 4'b1000;
        repeat (LAT) tick();
        tick();
        chk("level pending", in_port, 8'h08);
        wr(8'hF1, 8'h08);
        tick();
        tick();
        chk("level no reset", in_port, 8'h00);
        irq_req = 4'b0000;
        irq_req = 4'b0001;
        repeat (LAT - 1) tick();
        wr(8'hF1, 8'h01);
        irq_req = 4'b0000;
        tick();
        chk("set wins", in_port, 8'h01);
        wr(8'hF1, 8'h01);
        tick();
        chk("w1c bit0", in_port, 8'h00);
        port_id = 8'h21;
        out_port = 8'h99;
        write_strobe = 1'b1;
        tick();
        chk("pre-reset ch_wr", ch_wr, 4'b0100);
        reset_n = 1'b0;
        write_strobe = 1'b0;
        #1;
        chk("async ch_wr", ch_wr, 4'b0);
        chk("async ch_sel", ch_sel, 4'b0);
        chk("async ch_addr", ch_addr, 8'h00);
        chk("async ch_wdata", ch_wdata, 8'h00);
        chk("async in_port", in_port, 8'h00);
        tick();
        reset_n = 1'b1;
        port_id = 8'hF0;
        tick();
        chk("post-reset ch_wr", ch_wr, 4'b0);
        chk("post-reset mask", in_port, 8'h00);
        port_id = 8'hF1;
        tick();
        chk("post-reset pending", in_port, 8'h00);
        chk("post-reset interrupt", interrupt, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/micro_io_hub.md
Name: micro_io_hub

Overview:
- Parametrised I/O decode and interrupt hub between the KCPSM6 port bus and N peripheral channels (RTC, keyboard, VGA, sound, ...).
- Generalises the fixed four-strobe port decoder into N_CH address windows, adding:
  - a registered in_port read mux;
  - registered per-channel write/read strobes with window offset;
  - a maskable, edge-triggered interrupt controller with the KCPSM6 interrupt/interrupt_ack handshake.
- Sits directly beside the KCPSM6 instance; peripherals connect only to this block.

Parameters:
- N_CH, 4, number of peripheral channels, legal 1..8.
- CH_BASE, 8'h00, port address of channel 0 window.
- CH_SPAN, 16, window size in port addresses, power of 2; channel i occupies CH_BASE+i*CH_SPAN .. +CH_SPAN-1.
- CTRL_ADDR, 8'hF0, IRQ mask register; CTRL_ADDR+1 is the IRQ pending register.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- port_id  in  8  KCPSM6 port address.
- out_port  in  8  KCPSM6 write data.
- write_strobe  in  1  KCPSM6 write strobe.
- read_strobe  in  1  KCPSM6 read strobe.
- in_port  out  8  read data to KCPSM6.
- interrupt  out  1  interrupt request to KCPSM6.
- interrupt_ack  in  1  KCPSM6 interrupt acknowledge.
- ch_rdata  in  N_CH*8  channel read data, channel i at bits [8i+7:8i].
- ch_sel  out  N_CH  registered window-hit level.
- ch_wr  out  N_CH  one-cycle write pulse.
- ch_rd  out  N_CH  one-cycle read pulse.
- ch_addr  out  8  registered offset of port_id within its window.
- ch_wdata  out  8  registered write data.
- irq_req  in  N_CH  per-channel interrupt request, rising-edge significant.

Behaviour:
- Reset (async, reset_n=0): every output and every register clears to 0, including mask, pending, in_service and the edge-detect history. Reset mid-transfer drops any pending strobe; no pulse is emitted after release.
- Decode:
  - hit[i] = port_id within window i.
  - CTRL_ADDR and CTRL_ADDR+1 take priority over any overlapping window.
  - Addresses matching nothing produce no strobe.
- Write path: write_strobe with hit[i] at edge k gives, at edge k+1:
  - ch_wr[i]=1 for exactly one cycle;
  - ch_wdata=out_port;
  - ch_addr=port_id-window base.
- Read path: read_strobe with hit[i] gives ch_rd[i]=1 for one cycle at the following edge. Used by peripherals to pop FIFOs or clear flags.
- ch_sel: registered hit vector, updated every cycle, 1-cycle latency.
- in_port mux:
  - Registered every cycle from the current port_id, independent of read_strobe.
  - Sources: window i gives ch_rdata[i]; CTRL_ADDR gives the mask; CTRL_ADDR+1 gives pending. Both are zero-extended to 8 bits.
  - Unmapped addresses give 8'h00.
  - KCPSM6 holds port_id for 2 cycles, so the data is valid when read_strobe samples.
- Interrupt controller:
  - Rising edge on irq_req[i] sets pending[i]; a level held high does not re-set it after clearing.
  - Write to CTRL_ADDR loads mask[N_CH-1:0].
  - Write to CTRL_ADDR+1 clears pending bits where out_port bit=1 (W1C).
  - Same-cycle new edge and W1C on the same bit: set wins.
  - interrupt is registered: it rises the cycle after |(pending&mask)=1 while in_service=0.
  - interrupt_ack=1 drops interrupt at the next edge and sets in_service.
  - in_service clears on any W1C write to CTRL_ADDR+1. interrupt re-asserts the next cycle if masked pending bits remain.
  - Masking a pending bit does not clear it.
  - interrupt_ack while interrupt=0 is ignored.
- Simultaneous write_strobe and read_strobe (illegal on KCPSM6): both paths act independently.

Optional Feature:
- MICRO_IRQ_SYNC_EN.
  - Defined: each irq_req bit passes through a 2-flop synchronizer before edge detection. Edge-to-pending latency is 3 cycles, and the inputs may be asynchronous (keyboard, RTC).
  - Undefined: irq_req must be synchronous to clk. Edge-to-pending latency is 1 cycle.

Test Plan:
- Write 8'hA5 to port 8'h33 (defaults) -> next cycle ch_wr=4'b1000 for 1 cycle, ch_addr=8'h03, ch_wdata=8'hA5; ch_wr otherwise 0.
- ch_rdata[15:8]=8'h5C, port_id=8'h12 held 2 cycles, read_strobe in cycle 2 -> in_port=8'h5C at the read_strobe edge, ch_rd=4'b0010 one cycle later; port_id=8'h80 -> in_port=8'h00, no strobe.
- Write mask 8'h05, pulse irq_req[2] -> pending=4'b0100, interrupt=1; reading port 8'hF1 returns 8'h04.
- Continuing: interrupt_ack -> interrupt=0 next cycle; write 8'h04 to 8'hF1 -> pending=0, interrupt stays 0.
- Pulse irq_req[1] with mask 8'h05 -> pending=4'b0010, interrupt stays 0; write mask 8'h07 -> interrupt=1 next cycle.
- Same cycle: irq_req[0] edge and W1C 8'h01 to 8'hF1 -> pending[0]=1 remains.
- Assert reset_n=0 during a ch_wr cycle -> all outputs 0 immediately, mask/pending read 8'h00 after release.
